// File: rtl/sled_scan_ctrl.sv
// Scan controller for a 4-digit common-anode 7-segment display with blanking gaps.
// Holds per-digit hex/dp registers and an enable mask, and drives active-low seg/dig buses.
module sled_scan_ctrl #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [4:0] wr_data,
  output logic [7:0] seg,
  output logic [3:0] dig,
  output logic       frame_tick
);

  localparam int unsigned CntMax = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] DriveLast = CntW'(SCAN_DIV - 1);

  typedef enum logic [0:0] {StBlank, StDrive} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [7:0]      seg_q, seg_d;
  logic [3:0]      dig_q, dig_d;
  logic            tick_q, tick_d;

  logic [3:0]      value_q [4];
  logic [3:0]      dp_q;
  logic [3:0]      en_q;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    s = 7'h7F;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) value_q[i] <= 4'h0;
      dp_q <= 4'h0;
      en_q <= 4'hF;
    end else if (wr_en) begin
      if (wr_addr[2] == 1'b0) begin
        value_q[wr_addr[1:0]] <= wr_data[3:0];
        dp_q[wr_addr[1:0]]    <= wr_data[4];
      end else if (wr_addr == 3'd4) begin
        en_q <= wr_data[3:0];
      end
    end
  end

  // Outputs are loaded only on slot boundaries, so a mid-slot write cannot tear the display.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    idx_d   = idx_q;
    seg_d   = seg_q;
    dig_d   = dig_q;
    tick_d  = 1'b0;
    case (state_q)
      StBlank: begin
        if (cnt_q == BlankLast) begin
          state_d = StDrive;
          cnt_d   = '0;
          if (en_q[idx_q]) begin
            dig_d = ~(4'b0001 << idx_q);
            seg_d = {~dp_q[idx_q], decode(value_q[idx_q])};
          end else begin
            dig_d = 4'hF;
            seg_d = 8'hFF;
          end
        end
      end
      StDrive: begin
        if (cnt_q == DriveLast) begin
          state_d = StBlank;
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
          dig_d   = 4'hF;
          seg_d   = 8'hFF;
          tick_d  = (idx_q == 2'd3);
        end
      end
      default: begin
        state_d = StBlank;
        cnt_d   = '0;
        dig_d   = 4'hF;
        seg_d   = 8'hFF;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StBlank;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      seg_q   <= 8'hFF;
      dig_q   <= 4'hF;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      tick_q  <= tick_d;
    end
  end

  assign seg        = seg_q;
  assign dig        = dig_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_sled_scan_ctrl.sv
// Directed bench for sled_scan_ctrl: per-cycle expectations are queued when a cycle is driven
// and popped after the edge, plus literal spot checks of the display sequence.
module tb_sled_scan_ctrl;

  localparam int ScanDiv = 4;
  localparam int Blank   = 2;
  localparam int Slot    = ScanDiv + Blank;
  localparam int Frame   = 4 * Slot;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [4:0] wr_data = 5'd0;
  logic [7:0] seg;
  logic [3:0] dig;
  logic       frame_tick;

  sled_scan_ctrl #(
    .SCAN_DIV    (ScanDiv),
    .BLANK_CYCLES(Blank)
  ) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .seg       (seg),
    .dig       (dig),
    .frame_tick(frame_tick)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] dig;
    logic       tick;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         s        = 0;
  logic [3:0] m_val [4];
  logic [3:0] m_dp;
  logic [3:0] m_en;
  logic       snap_en;
  logic [7:0] snap_seg;
  logic [7:0] dec_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s at sample %0d: observed=%h expected=%h", tag, s, obs, want);
    end
  endtask

  task automatic shadow_clear();
    for (int i = 0; i < 4; i++) m_val[i] = 4'h0;
    m_dp     = 4'h0;
    m_en     = 4'hF;
    snap_en  = 1'b0;
    snap_seg = 8'hFF;
  endtask

  task automatic shadow_write(input logic [2:0] a, input logic [4:0] d);
    if (a < 3'd4) begin
      m_val[a[1:0]] = d[3:0];
      m_dp[a[1:0]]  = d[4];
    end else if (a == 3'd4) begin
      m_en = d[3:0];
    end
  endtask

  // Expected outputs for sample s, from the slot position within the 24-cycle frame.
  task automatic push_expected();
    int         p, off;
    logic [1:0] slot;
    exp_t       e;
    p    = s % Frame;
    slot = 2'(p / Slot);
    off  = p % Slot;
    e.tick = (p == 0) && (s != 0);
    if (off < Blank) begin
      e.seg = 8'hFF;
      e.dig = 4'hF;
    end else begin
      if (off == Blank) begin
        snap_en  = m_en[slot];
        snap_seg = dec_tab[m_val[slot]];
        if (m_dp[slot]) snap_seg[7] = 1'b0;
      end
      e.seg = snap_en ? snap_seg : 8'hFF;
      e.dig = snap_en ? ~(4'b0001 << slot) : 4'hF;
    end
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 8'd0, 8'd1);
    end else begin
      e = sb.pop_front();
      chk("seg", seg, e.seg);
      chk("dig", {4'h0, dig}, {4'h0, e.dig});
      chk("frame_tick", {7'h0, frame_tick}, {7'h0, e.tick});
      chk("dig_at_most_one_low", {7'h0, ($countones(~dig) <= 1)}, 8'd1);
    end
  endtask

  task automatic cycle(input logic we, input logic [2:0] a, input logic [4:0] d);
    wr_en   = we;
    wr_addr = a;
    wr_data = d;
    s++;
    push_expected();
    if (we) shadow_write(a, d);
    @(posedge clock);
    @(negedge clock);
    wr_en = 1'b0;
    pop_check();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 5'd0);
  endtask

  task automatic run_to(input int p);
    for (int i = 0; i < Frame && (s % Frame) != p; i++) cycle(1'b0, 3'd0, 5'd0);
  endtask

  task automatic lit(input string tag, input logic [7:0] want_seg, input logic [3:0] want_dig);
    chk({tag, "_seg"}, seg, want_seg);
    chk({tag, "_dig"}, {4'h0, dig}, {4'h0, want_dig});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr_en = 1'b0;
    @(negedge clock);
    @(negedge clock);
    rst_n = 1'b1;
    shadow_clear();
    s = 0;
    sb.delete();
    push_expected();
    pop_check();
  endtask

  initial begin
    shadow_clear();

    // 1: reset defaults, zeros shown on every digit
    do_reset();
    lit("reset", 8'hFF, 4'hF);
    idle(2);
    lit("t1_d0", 8'hC0, 4'hE);
    run_to(8);
    lit("t1_d1", 8'hC0, 4'hD);
    idle(Frame);
    run_to(0);

    // 2: digits 1..4
    cycle(1'b1, 3'd0, 5'h01);
    cycle(1'b1, 3'd1, 5'h02);
    cycle(1'b1, 3'd2, 5'h03);
    cycle(1'b1, 3'd3, 5'h04);
    run_to(0);
    chk("t2_tick", {7'h0, frame_tick}, 8'd1);
    run_to(2);
    lit("t2_d0", 8'hF9, 4'hE);
    run_to(8);
    lit("t2_d1", 8'hA4, 4'hD);
    run_to(14);
    lit("t2_d2", 8'hB0, 4'hB);
    run_to(20);
    lit("t2_d3", 8'h99, 4'h7);
    run_to(0);

    // 3: enable mask 0101
    cycle(1'b1, 3'd4, 5'h05);
    run_to(0);
    run_to(2);
    lit("t3_d0", 8'hF9, 4'hE);
    run_to(8);
    lit("t3_d1_dark", 8'hFF, 4'hF);
    run_to(14);
    lit("t3_d2", 8'hB0, 4'hB);
    run_to(20);
    lit("t3_d3_dark", 8'hFF, 4'hF);
    run_to(0);

    // 4: dp + 8, then rewrite mid-slot
    cycle(1'b1, 3'd2, 5'h18);
    run_to(14);
    lit("t4_d2_dp8", 8'h00, 4'hB);
    cycle(1'b1, 3'd2, 5'h05);
    lit("t4_no_tear", 8'h00, 4'hB);
    run_to(17);
    lit("t4_no_tear_end", 8'h00, 4'hB);
    run_to(0);
    run_to(14);
    lit("t4_d2_five", 8'h92, 4'hB);

    // 5: asynchronous reset in the middle of a drive slot
    run_to(16);
    lit("t5_pre", 8'h92, 4'hB);
    #2;
    rst_n = 1'b0;
    #1;
    lit("t5_async", 8'hFF, 4'hF);
    chk("t5_async_tick", {7'h0, frame_tick}, 8'd0);
    do_reset();
    idle(2);
    lit("t5_restart_d0", 8'hC0, 4'hE);
    run_to(14);
    lit("t5_cleared_d2", 8'hC0, 4'hB);
    run_to(0);

    // 6: ignored addresses and back-to-back writes
    cycle(1'b1, 3'd5, 5'h1F);
    cycle(1'b1, 3'd6, 5'h00);
    cycle(1'b1, 3'd7, 5'h1A);
    cycle(1'b1, 3'd0, 5'h03);
    cycle(1'b1, 3'd0, 5'h07);
    cycle(1'b1, 3'd1, 5'h1A);
    cycle(1'b1, 3'd1, 5'h0A);
    cycle(1'b1, 3'd4, 5'h00);
    cycle(1'b1, 3'd4, 5'h0F);
    run_to(0);
    run_to(2);
    lit("t6_d0", 8'hF8, 4'hE);
    run_to(8);
    lit("t6_d1", 8'h88, 4'hD);
    run_to(20);
    lit("t6_d3", 8'hC0, 4'h7);
    run_to(0);
    idle(Frame);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
